// File: rtl/gerador_codigo.sv
// Prescaled up/down code sequencer feeding the seven-segment decoder input.
// Codes run 0..MAX with wrap-around; synchronous load clamps to MAX and beats a pending step.
module gerador_codigo #(
  parameter int DIV = 4,
  parameter int MAX = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       habilita,
  input  logic       direcao,
  input  logic       carrega,
  input  logic [0:4] valor_carga,
  output logic [0:4] codigo,
  output logic       passo,
  output logic       volta,
  output logic       ativo
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] ULTIMO = PW'(DIV - 1);
  localparam logic [PW-1:0] UM     = PW'(1);
  localparam logic [4:0]    TOPO   = 5'(MAX);

  typedef enum logic {PARADO, CONTANDO} estado_t;

  estado_t       estado, estado_next;
  logic [PW-1:0] presc, presc_next;
  logic [4:0]    cod, cod_next, carga;
  logic          passo_next, volta_next;

  // Bit 0 of the [0:4] ports is the MSB, so a plain assignment keeps the numeric value.
  assign carga  = valor_carga;
  assign codigo = cod;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado <= PARADO;
      presc  <= '0;
      cod    <= '0;
      passo  <= 1'b0;
      volta  <= 1'b0;
    end else begin
      estado <= estado_next;
      presc  <= presc_next;
      cod    <= cod_next;
      passo  <= passo_next;
      volta  <= volta_next;
    end
  end

  // NOTE: every variable gets a default first so no path through the block infers a latch.
  always_comb begin
    estado_next = estado;
    presc_next  = presc;
    cod_next    = cod;
    passo_next  = 1'b0;
    volta_next  = 1'b0;
    if (carrega) begin
      cod_next    = (carga > TOPO) ? TOPO : carga;
      presc_next  = '0;
      estado_next = habilita ? CONTANDO : PARADO;
    end else if (habilita) begin
      estado_next = CONTANDO;
      if (estado == CONTANDO) begin
        if (presc == ULTIMO) begin
          presc_next = '0;
          passo_next = 1'b1;
          if (direcao) begin
            if (cod == 5'd0) begin
              cod_next   = TOPO;
              volta_next = 1'b1;
            end else begin
              cod_next = cod - 5'd1;
            end
          end else begin
            if (cod == TOPO) begin
              cod_next   = 5'd0;
              volta_next = 1'b1;
            end else begin
              cod_next = cod + 5'd1;
            end
          end
        end else begin
          presc_next = presc + UM;
        end
      end
    end else begin
      estado_next = PARADO;
      presc_next  = '0;
    end
  end

  always_comb begin
    ativo = (estado == CONTANDO);
  end

endmodule

// File: tb/tb_gerador_codigo.sv
// Bench for gerador_codigo: DUT a (DIV=4, MAX=31) and DUT b (DIV=1, MAX=9) share stimulus.
// Directed scenarios use spec-derived constants; a random run is checked against a cycle model.
module tb_gerador_codigo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       habilita = 1'b0;
  logic       direcao = 1'b0;
  logic       carrega = 1'b0;
  logic [0:4] valor_carga = 5'd0;

  logic [0:4] codigo_a, codigo_b;
  logic       passo_a, volta_a, ativo_a;
  logic       passo_b, volta_b, ativo_b;

  int n_checks = 0;
  int n_pass   = 0;

  gerador_codigo #(.DIV(4), .MAX(31)) dut_a (
    .clk(clk), .rst(rst), .habilita(habilita), .direcao(direcao), .carrega(carrega),
    .valor_carga(valor_carga), .codigo(codigo_a), .passo(passo_a), .volta(volta_a), .ativo(ativo_a)
  );

  gerador_codigo #(.DIV(1), .MAX(9)) dut_b (
    .clk(clk), .rst(rst), .habilita(habilita), .direcao(direcao), .carrega(carrega),
    .valor_carga(valor_carga), .codigo(codigo_b), .passo(passo_b), .volta(volta_b), .ativo(ativo_b)
  );

  always #5 clk = ~clk;

  // Reference model: interval position counted in cycles, codes advanced modulo MAX+1.
  int p_div[2] = '{4, 1};
  int p_max[2] = '{31, 9};
  int m_code[2] = '{0, 0};
  int m_cnt[2]  = '{0, 0};
  bit m_run[2]   = '{0, 0};
  bit m_passo[2] = '{0, 0};
  bit m_volta[2] = '{0, 0};

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_code[i] = 0; m_cnt[i] = 0; m_run[i] = 0; m_passo[i] = 0; m_volta[i] = 0;
      end else if (carrega) begin
        m_code[i]  = (int'(valor_carga) > p_max[i]) ? p_max[i] : int'(valor_carga);
        m_cnt[i]   = 0;
        m_passo[i] = 0;
        m_volta[i] = 0;
        m_run[i]   = habilita;
      end else if (habilita) begin
        if (m_run[i] && m_cnt[i] == p_div[i] - 1) begin
          m_cnt[i]   = 0;
          m_passo[i] = 1;
          if (direcao) begin
            m_volta[i] = (m_code[i] == 0);
            m_code[i]  = (m_code[i] + p_max[i]) % (p_max[i] + 1);
          end else begin
            m_volta[i] = (m_code[i] == p_max[i]);
            m_code[i]  = (m_code[i] + 1) % (p_max[i] + 1);
          end
        end else begin
          if (m_run[i]) m_cnt[i]++;
          m_passo[i] = 0;
          m_volta[i] = 0;
        end
        m_run[i] = 1;
      end else begin
        m_run[i] = 0; m_cnt[i] = 0; m_passo[i] = 0; m_volta[i] = 0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    for (int n = 0; n < 6; n++) begin
      habilita    = 1'($urandom);
      direcao     = 1'($urandom);
      carrega     = 1'($urandom);
      valor_carga = 5'($urandom);
      #3;
      n_checks++;
      if ({codigo_a, passo_a, volta_a, ativo_a, codigo_b, passo_b, volta_b, ativo_b} !== 16'h0000)
        $display("FAIL reset: got a=%0d/%b%b%b b=%0d/%b%b%b required all zero",
                 codigo_a, passo_a, volta_a, ativo_a, codigo_b, passo_b, volta_b, ativo_b);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_count_up;
    carrega = 0; direcao = 0; habilita = 1; rst = 0;
    for (int k = 0; k <= 12; k++) begin
      tick();
      n_checks++;
      if ({codigo_a, passo_a, volta_a, ativo_a} !== {5'(k / 4), (k > 0 && k % 4 == 0), 1'b0, 1'b1})
        $display("FAIL count_up_a edge %0d: got %0d/%b%b%b required %0d", k,
                 codigo_a, passo_a, volta_a, ativo_a, k / 4);
      else n_pass++;
      n_checks++;
      if ({codigo_b, passo_b, volta_b, ativo_b} !== {5'(k % 10), (k > 0), (k > 0 && k % 10 == 0), 1'b1})
        $display("FAIL count_up_b edge %0d: got %0d/%b%b%b required %0d", k,
                 codigo_b, passo_b, volta_b, ativo_b, k % 10);
      else n_pass++;
    end
  endtask

  task automatic test_wrap;
    carrega = 1; valor_carga = 5'd31; habilita = 1; direcao = 0;
    tick();
    n_checks++;
    if ({codigo_a, passo_a, volta_a, ativo_a} !== {5'd31, 1'b0, 1'b0, 1'b1})
      $display("FAIL wrap_load_a: got %0d/%b%b%b required 31/001", codigo_a, passo_a, volta_a, ativo_a);
    else n_pass++;
    n_checks++;
    if ({codigo_b, passo_b, ativo_b} !== {5'd9, 1'b0, 1'b1})
      $display("FAIL wrap_load_clamp_b: got %0d/%b%b required 9/01", codigo_b, passo_b, ativo_b);
    else n_pass++;
    carrega = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++;
      if ({codigo_a, passo_a, volta_a, ativo_a} !== {(i == 4) ? 5'd0 : 5'd31, (i == 4), (i == 4), 1'b1})
        $display("FAIL wrap_up cycle %0d: got %0d/%b%b%b", i, codigo_a, passo_a, volta_a, ativo_a);
      else n_pass++;
    end
    direcao = 1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++;
      if ({codigo_a, passo_a, volta_a, ativo_a} !== {(i == 4) ? 5'd31 : 5'd0, (i == 4), (i == 4), 1'b1})
        $display("FAIL wrap_down cycle %0d: got %0d/%b%b%b", i, codigo_a, passo_a, volta_a, ativo_a);
      else n_pass++;
    end
  endtask

  task automatic test_load_clamp;
    habilita = 0; direcao = 0; carrega = 1; valor_carga = 5'd25;
    tick();
    n_checks++;
    if ({codigo_a, passo_a, volta_a, ativo_a, codigo_b, passo_b, volta_b, ativo_b} !==
        {5'd25, 3'b000, 5'd9, 3'b000})
      $display("FAIL load_clamp: got a=%0d b=%0d ativo=%b%b required a=25 b=9 ativo=00",
               codigo_a, codigo_b, ativo_a, ativo_b);
    else n_pass++;
    carrega = 0; habilita = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({codigo_a, passo_a, volta_a, ativo_a} !== {5'd25, 3'b001})
        $display("FAIL load_wait cycle %0d: got %0d/%b%b%b required 25/001", i,
                 codigo_a, passo_a, volta_a, ativo_a);
      else n_pass++;
    end
    carrega = 1; valor_carga = 5'b00100;
    tick();
    n_checks++;
    if ({codigo_a, passo_a, volta_a, ativo_a} !== {5'd4, 3'b001})
      $display("FAIL load_beats_step: got %0d/%b%b%b required 4/001", codigo_a, passo_a, volta_a, ativo_a);
    else n_pass++;
    carrega = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++;
      if ({codigo_a, passo_a, volta_a, ativo_a} !== {(i == 4) ? 5'd5 : 5'd4, (i == 4), 1'b0, 1'b1})
        $display("FAIL after_load cycle %0d: got %0d/%b%b%b", i, codigo_a, passo_a, volta_a, ativo_a);
      else n_pass++;
    end
  endtask

  task automatic test_pause_resume;
    for (int i = 0; i < 3; i++) tick();
    habilita = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({codigo_a, passo_a, volta_a, ativo_a} !== {5'd5, 3'b000})
        $display("FAIL pause cycle %0d: got %0d/%b%b%b required 5/000", i, codigo_a, passo_a, volta_a, ativo_a);
      else n_pass++;
    end
    habilita = 1;
    tick();
    n_checks++;
    if ({codigo_a, passo_a, volta_a, ativo_a} !== {5'd5, 3'b001})
      $display("FAIL resume: got %0d/%b%b%b required 5/001", codigo_a, passo_a, volta_a, ativo_a);
    else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++;
      if ({codigo_a, passo_a, volta_a, ativo_a} !== {(i == 4) ? 5'd6 : 5'd5, (i == 4), 1'b0, 1'b1})
        $display("FAIL after_resume cycle %0d: got %0d/%b%b%b", i, codigo_a, passo_a, volta_a, ativo_a);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_run;
    carrega = 1; valor_carga = 5'd17; habilita = 1; direcao = 0;
    tick();
    n_checks++;
    if (codigo_a !== 5'd17)
      $display("FAIL load_17: got %0d required 17", codigo_a);
    else n_pass++;
    carrega = 0;
    tick();
    tick();
    #2 rst = 1;
    #1;
    n_checks++;
    if ({codigo_a, passo_a, volta_a, ativo_a, codigo_b, passo_b, volta_b, ativo_b} !== 16'h0000)
      $display("FAIL reset_async: got a=%0d/%b%b%b b=%0d/%b%b%b required all zero",
               codigo_a, passo_a, volta_a, ativo_a, codigo_b, passo_b, volta_b, ativo_b);
    else n_pass++;
    @(negedge clk);
    rst = 0;
    for (int k = 0; k <= 8; k++) begin
      tick();
      n_checks++;
      if ({codigo_a, passo_a, volta_a, ativo_a} !== {5'(k / 4), (k > 0 && k % 4 == 0), 1'b0, 1'b1})
        $display("FAIL restart_a edge %0d: got %0d/%b%b%b required %0d", k,
                 codigo_a, passo_a, volta_a, ativo_a, k / 4);
      else n_pass++;
      n_checks++;
      if ({codigo_b, passo_b, volta_b, ativo_b} !== {5'(k), (k > 0), 1'b0, 1'b1})
        $display("FAIL restart_b edge %0d: got %0d/%b%b%b required %0d", k,
                 codigo_b, passo_b, volta_b, ativo_b, k);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(0, 63) == 0);
      carrega     = ($urandom_range(0, 9) == 0);
      habilita    = ($urandom_range(0, 7) != 0);
      direcao     = 1'($urandom);
      valor_carga = 5'($urandom);
      tick();
      n_checks++;
      if ({codigo_a, passo_a, volta_a, ativo_a} !== {5'(m_code[0]), m_passo[0], m_volta[0], m_run[0]})
        $display("FAIL random_a cycle %0d: got %0d/%b%b%b required %0d/%b%b%b", n,
                 codigo_a, passo_a, volta_a, ativo_a, m_code[0], m_passo[0], m_volta[0], m_run[0]);
      else n_pass++;
      n_checks++;
      if ({codigo_b, passo_b, volta_b, ativo_b} !== {5'(m_code[1]), m_passo[1], m_volta[1], m_run[1]})
        $display("FAIL random_b cycle %0d: got %0d/%b%b%b required %0d/%b%b%b", n,
                 codigo_b, passo_b, volta_b, ativo_b, m_code[1], m_passo[1], m_volta[1], m_run[1]);
      else n_pass++;
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_load_clamp();
    test_pause_resume();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
